// File: rtl/code2421_pkg.sv
// Shared definitions for the two-digit 2421-coded sequence controller.
// Contents: controller state enum, the ten 2421 digit codes, the legal-code
// check and decimal step helpers used by the digit cells.
package code2421_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] D0 = 4'b0000;
  localparam logic [3:0] D1 = 4'b0001;
  localparam logic [3:0] D2 = 4'b0010;
  localparam logic [3:0] D3 = 4'b0011;
  localparam logic [3:0] D4 = 4'b0100;
  localparam logic [3:0] D5 = 4'b1011;
  localparam logic [3:0] D6 = 4'b1100;
  localparam logic [3:0] D7 = 4'b1101;
  localparam logic [3:0] D8 = 4'b1110;
  localparam logic [3:0] D9 = 4'b1111;

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      D0, D1, D2, D3, D4, D5, D6, D7, D8, D9: is_legal = 1'b1;
      default:                                is_legal = 1'b0;
    endcase
  endfunction

  // Illegal codes map to 0; callers only step legal digits.
  function automatic logic [3:0] code2dec(input logic [3:0] c);
    case (c)
      D1:      code2dec = 4'd1;
      D2:      code2dec = 4'd2;
      D3:      code2dec = 4'd3;
      D4:      code2dec = 4'd4;
      D5:      code2dec = 4'd5;
      D6:      code2dec = 4'd6;
      D7:      code2dec = 4'd7;
      D8:      code2dec = 4'd8;
      D9:      code2dec = 4'd9;
      default: code2dec = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] dec2code(input logic [3:0] d);
    case (d)
      4'd1:    dec2code = D1;
      4'd2:    dec2code = D2;
      4'd3:    dec2code = D3;
      4'd4:    dec2code = D4;
      4'd5:    dec2code = D5;
      4'd6:    dec2code = D6;
      4'd7:    dec2code = D7;
      4'd8:    dec2code = D8;
      4'd9:    dec2code = D9;
      default: dec2code = D0;
    endcase
  endfunction

  function automatic logic [3:0] step_up(input logic [3:0] c);
    logic [3:0] d;
    d = code2dec(c);
    step_up = dec2code((d == 4'd9) ? 4'd0 : d + 4'd1);
  endfunction

  function automatic logic [3:0] step_dn(input logic [3:0] c);
    logic [3:0] d;
    d = code2dec(c);
    step_dn = dec2code((d == 4'd0) ? 4'd9 : d - 4'd1);
  endfunction

endpackage

// File: rtl/code2421_seq_ctrl_digit.sv
// One 2421-coded decimal digit register.
// Ports: clk/rst (sync, active-high); load_i/load_val_i load a code;
// inc_i steps +1 (9 wraps to 0); nxt_o is the value a step would produce;
// carry_o flags a 9->0 step; legal_o reports whether load_val_i is a legal code.
// With CODE2421_DOWN_EN defined: dec_i steps -1 and borrow_o flags 0->9.
module code2421_digit
  import code2421_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
`ifdef CODE2421_DOWN_EN
  input  logic       dec_i,
  output logic       borrow_o,
`endif
  output logic [3:0] q_o,
  output logic [3:0] nxt_o,
  output logic       carry_o,
  output logic       legal_o
);

  logic [3:0] q_q, q_d;

  always_comb begin
`ifdef CODE2421_DOWN_EN
    nxt_o = dec_i ? step_dn(q_q) : step_up(q_q);
`else
    nxt_o = step_up(q_q);
`endif
  end

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (inc_i) begin
      q_d = nxt_o;
`ifdef CODE2421_DOWN_EN
    end else if (dec_i) begin
      q_d = nxt_o;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o      = q_q;
  assign carry_o  = inc_i & (q_q == D9);
`ifdef CODE2421_DOWN_EN
  assign borrow_o = dec_i & (q_q == D0);
`endif
  assign legal_o  = is_legal(load_val_i);

endmodule

// File: rtl/code2421_seq_ctrl.sv
// Two-digit 2421-coded sequence counter with start/pause/stop control.
// Ports: clk, rst (sync, active-high); start/load sampled in IDLE only
// (load wins); pause holds counting; stop aborts to IDLE keeping out;
// load_val/limit are {tens,units} 2421 codes; out is the count; busy is high
// in RUN/HOLD; done pulses for one cycle on reaching limit; err is a sticky
// illegal-code flag cleared by a legal load.
// Parameter PRESCALE (1..255): RUN cycles per count advance.
// Optional macro CODE2421_DOWN_EN adds input dir (0 = up, 1 = down).
module code2421_seq_ctrl
  import code2421_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] limit,
`ifdef CODE2421_DOWN_EN
  input  logic       dir,
`endif
  output logic [7:0] out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  state_e     state_q, state_d;
  logic [7:0] pre_q, pre_d;
  logic       err_q, err_d;

  logic [3:0] u_q, u_nxt, t_q, t_nxt;
  logic       u_cy, t_cy, u_ok, t_ok, u_step;
  logic       limit_ok, do_load, run_act, adv, adv_up, adv_dn, hit;
  logic [7:0] new_val;

  assign limit_ok = is_legal(limit[7:4]) & is_legal(limit[3:0]);
  assign do_load  = (state_q == IDLE) & load & u_ok & t_ok;
  // Pause and stop both suppress prescale progress in the cycle they are seen.
  assign run_act  = (state_q == RUN) & ~stop & ~pause;
  assign adv      = run_act & (pre_q == PRE_LAST);

`ifdef CODE2421_DOWN_EN
  logic u_bw, t_bw;
  assign adv_up = adv & ~dir;
  assign adv_dn = adv & dir;
  assign u_step = u_cy | u_bw;
`else
  assign adv_up = adv;
  assign adv_dn = 1'b0;
  assign u_step = u_cy;
`endif

  // Value out will hold after this advance; tens only moves on carry/borrow.
  assign new_val = {(u_step ? t_nxt : t_q), u_nxt};
  assign hit     = (new_val == limit);

  code2421_digit u_units (
    .clk        (clk),
    .rst        (rst),
    .load_i     (do_load),
    .load_val_i (load_val[3:0]),
    .inc_i      (adv_up),
`ifdef CODE2421_DOWN_EN
    .dec_i      (adv_dn),
    .borrow_o   (u_bw),
`endif
    .q_o        (u_q),
    .nxt_o      (u_nxt),
    .carry_o    (u_cy),
    .legal_o    (u_ok)
  );

  code2421_digit u_tens (
    .clk        (clk),
    .rst        (rst),
    .load_i     (do_load),
    .load_val_i (load_val[7:4]),
    .inc_i      (u_cy),
`ifdef CODE2421_DOWN_EN
    .dec_i      (u_bw),
    .borrow_o   (t_bw),
`endif
    .q_o        (t_q),
    .nxt_o      (t_nxt),
    .carry_o    (t_cy),
    .legal_o    (t_ok)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!stop && !load && start && limit_ok && !err_q) state_d = RUN;
      RUN: begin
        if (stop)            state_d = IDLE;
        else if (pause)      state_d = HOLD;
        else if (adv && hit) state_d = DONE;
      end
      HOLD: begin
        if (stop)        state_d = IDLE;
        else if (!pause) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Prescale counter and error flag
  always_comb begin
    pre_d = pre_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        pre_d = '0;
        if (load)                       err_d = ~(u_ok & t_ok);
        else if (start && !limit_ok)    err_d = 1'b1;
      end
      RUN: if (run_act) pre_d = adv ? 8'd0 : pre_q + 8'd1;
      default: ;
    endcase
  end

  // Outputs (registered state only)
  always_comb begin
    busy = (state_q == RUN) | (state_q == HOLD);
    done = (state_q == DONE);
  end

  assign out = {t_q, u_q};
  assign err = err_q;

`ifdef CODE2421_DOWN_EN
  logic unused_ok;
  assign unused_ok = t_cy ^ t_bw;
`else
  logic unused_ok;
  assign unused_ok = t_cy ^ adv_dn;
`endif

endmodule

// File: tb/tb_code2421_seq_ctrl.sv
module tb_code2421_seq_ctrl;

  localparam logic [3:0] CODES [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                                        4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  localparam int M_IDLE = 0, M_RUN = 1, M_HELD = 2, M_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, pause = 1'b0, stop = 1'b0, load = 1'b0;
  logic [7:0] load_val = '0, limit = '0;
  logic       dir = 1'b0;
  logic [7:0] out1, out3;
  logic       busy1, done1, err1, busy3, done3, err3;

  code2421_seq_ctrl #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .load(load), .load_val(load_val), .limit(limit),
`ifdef CODE2421_DOWN_EN
    .dir(dir),
`endif
    .out(out1), .busy(busy1), .done(done1), .err(err1));

  code2421_seq_ctrl #(.PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .load(load), .load_val(load_val), .limit(limit),
`ifdef CODE2421_DOWN_EN
    .dir(dir),
`endif
    .out(out3), .busy(busy3), .done(done3), .err(err3));

  int unsigned n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [7:0] enc(input int v);
    return {CODES[v / 10], CODES[v % 10]};
  endfunction

  function automatic int nib(input logic [3:0] n);
    for (int i = 0; i < 10; i++) if (CODES[i] == n) return i;
    return -1;
  endfunction

  function automatic bit legal8(input logic [7:0] v);
    return (nib(v[7:4]) >= 0) && (nib(v[3:0]) >= 0);
  endfunction

  typedef struct {
    int cnt;
    int mode;
    int ticks;
    bit err;
  } mdl_t;

  mdl_t m1, m3;

  function automatic mdl_t mstep(input mdl_t m, input int pre);
    mdl_t r;
    bit dn;
    r  = m;
    dn = 1'b0;
`ifdef CODE2421_DOWN_EN
    dn = dir;
`endif
    if (rst) begin
      r.cnt = 0; r.mode = M_IDLE; r.ticks = 0; r.err = 0;
      return r;
    end
    case (m.mode)
      M_IDLE: begin
        if (load) begin
          if (legal8(load_val)) begin
            r.cnt = nib(load_val[7:4]) * 10 + nib(load_val[3:0]);
            r.err = 0;
          end else r.err = 1;
        end else if (start) begin
          if (!legal8(limit)) r.err = 1;
          else if (!m.err && !stop) begin r.mode = M_RUN; r.ticks = 0; end
        end
      end
      M_RUN: begin
        if (stop) r.mode = M_IDLE;
        else if (pause) r.mode = M_HELD;
        else begin
          r.ticks++;
          if (r.ticks == pre) begin
            r.ticks = 0;
            r.cnt = dn ? (r.cnt + 99) % 100 : (r.cnt + 1) % 100;
            if (enc(r.cnt) == limit) r.mode = M_DONE;
          end
        end
      end
      M_HELD: begin
        if (stop) r.mode = M_IDLE;
        else if (!pause) r.mode = M_RUN;
      end
      default: r.mode = M_IDLE;
    endcase
    return r;
  endfunction

  task automatic cmp_model(input string tag, input mdl_t m, input logic [7:0] o,
                           input logic b, input logic d, input logic e);
    chk({tag, ".out"},  o, enc(m.cnt));
    chk({tag, ".busy"}, b, (m.mode == M_RUN) || (m.mode == M_HELD));
    chk({tag, ".done"}, d, m.mode == M_DONE);
    chk({tag, ".err"},  e, m.err);
  endtask

  // One clock: model sees the same inputs the DUTs sample, outputs read #1 later.
  task automatic step();
    @(posedge clk);
    m1 = mstep(m1, 1);
    m3 = mstep(m3, 3);
    #1;
    cmp_model("m1", m1, out1, busy1, done1, err1);
    cmp_model("m3", m3, out3, busy3, done3, err3);
  endtask

  task automatic setin(input bit r, input bit s, input bit p, input bit st, input bit l,
                       input logic [7:0] lv, input logic [7:0] lim);
    rst = r; start = s; pause = p; stop = st; load = l; load_val = lv; limit = lim;
  endtask

  // ---------------- directed table (PRESCALE=1 instance) ----------------
  typedef struct {
    bit r, s, p, st, l;
    logic [7:0] lv, lim, e_out;
    bit e_busy, e_done, e_err;
  } vec_t;

  function automatic vec_t V(input bit r, s, p, st, l, input logic [7:0] lv, lim, eo,
                             input bit eb, ed, ee);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.st = st; v.l = l;
    v.lv = lv; v.lim = lim; v.e_out = eo;
    v.e_busy = eb; v.e_done = ed; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl [25];

  logic [7:0] pexp [12];
  bit         ppat [12];
  int         n;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    //            r s p st l  lv     lim    out    b d e
    tbl[0]  = V(1,0,0,0,0, 8'h00, 8'h00, 8'h00, 0,0,0);
    tbl[1]  = V(0,0,0,0,1, 8'h0B, 8'h00, 8'h0B, 0,0,0);
    tbl[2]  = V(0,0,0,0,1, 8'h0F, 8'h12, 8'h0F, 0,0,0);
    tbl[3]  = V(0,1,0,0,0, 8'h00, 8'h12, 8'h0F, 1,0,0);
    tbl[4]  = V(0,0,0,0,0, 8'h00, 8'h12, 8'h10, 1,0,0);
    tbl[5]  = V(0,0,0,0,0, 8'h00, 8'h12, 8'h11, 1,0,0);
    tbl[6]  = V(0,0,0,0,0, 8'h00, 8'h12, 8'h12, 0,1,0);
    tbl[7]  = V(0,0,0,0,0, 8'h00, 8'h12, 8'h12, 0,0,0);
    tbl[8]  = V(0,0,0,0,1, 8'hFF, 8'h01, 8'hFF, 0,0,0);
    tbl[9]  = V(0,1,0,0,0, 8'h00, 8'h01, 8'hFF, 1,0,0);
    tbl[10] = V(0,0,0,0,0, 8'h00, 8'h01, 8'h00, 1,0,0);
    tbl[11] = V(0,0,0,0,0, 8'h00, 8'h01, 8'h01, 0,1,0);
    tbl[12] = V(0,0,0,0,0, 8'h00, 8'h01, 8'h01, 0,0,0);
    tbl[13] = V(0,0,0,0,1, 8'h05, 8'h01, 8'h01, 0,0,1);
    tbl[14] = V(0,1,0,0,0, 8'h00, 8'h01, 8'h01, 0,0,1);
    tbl[15] = V(0,0,0,0,0, 8'h00, 8'h01, 8'h01, 0,0,1);
    tbl[16] = V(0,0,0,0,1, 8'h0B, 8'h01, 8'h0B, 0,0,0);
    tbl[17] = V(0,1,0,0,0, 8'h00, 8'h55, 8'h0B, 0,0,1);
    tbl[18] = V(0,0,0,0,1, 8'h00, 8'h00, 8'h00, 0,0,0);
    tbl[19] = V(0,1,0,0,1, 8'h03, 8'h0F, 8'h03, 0,0,0);
    tbl[20] = V(0,0,0,0,0, 8'h00, 8'h0F, 8'h03, 0,0,0);
    tbl[21] = V(0,1,0,0,0, 8'h00, 8'h0F, 8'h03, 1,0,0);
    tbl[22] = V(0,0,0,0,0, 8'h00, 8'h0F, 8'h04, 1,0,0);
    tbl[23] = V(0,0,1,1,0, 8'h00, 8'h0F, 8'h04, 0,0,0);
    tbl[24] = V(0,0,0,0,0, 8'h00, 8'h0F, 8'h04, 0,0,0);

    m1 = '{0, M_IDLE, 0, 1'b0};
    m3 = '{0, M_IDLE, 0, 1'b0};

    for (int i = 0; i < 25; i++) begin
      setin(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].st, tbl[i].l, tbl[i].lv, tbl[i].lim);
      step();
      chk($sformatf("tbl%0d.out", i),  out1,  tbl[i].e_out);
      chk($sformatf("tbl%0d.busy", i), busy1, tbl[i].e_busy);
      chk($sformatf("tbl%0d.done", i), done1, tbl[i].e_done);
      chk($sformatf("tbl%0d.err", i),  err1,  tbl[i].e_err);
    end

    // Start with out already equal to limit: a full 100-step lap before done.
    setin(0,1,0,0,0, 8'h00, 8'h04);
    step();
    setin(0,0,0,0,0, 8'h00, 8'h04);
    n = 0;
    while (!done1 && n < 150) begin
      step();
      n++;
    end
    chk("lap100.steps", n, 100);
    chk("lap100.out", out1, 8'h04);
    step();

    // PRESCALE=3 with a 5-cycle pause in the middle of a prescale period.
    setin(1,0,0,0,0, 8'h00, 8'hFF); step();
    setin(0,0,0,0,1, 8'h00, 8'hFF); step();
    setin(0,1,0,0,0, 8'h00, 8'hFF); step();
    chk("pause.busy3", busy3, 1'b1);
    ppat = '{0,0,0,0,1,1,1,1,1,0,0,0};
    pexp = '{8'h00,8'h00,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h01,8'h02};
    for (int i = 0; i < 12; i++) begin
      setin(0,0,ppat[i],0,0, 8'h00, 8'hFF);
      step();
      chk($sformatf("pause%0d.out3", i), out3, pexp[i]);
    end
    setin(0,0,0,1,0, 8'h00, 8'hFF); step();
    chk("pause.stop.busy3", busy3, 1'b0);

`ifdef CODE2421_DOWN_EN
    // Down count from 00 wraps to 99.
    setin(1,0,0,0,0, 8'h00, 8'hFF); step();
    setin(0,0,0,0,1, 8'h00, 8'hFF); step();
    dir = 1'b1;
    setin(0,1,0,0,0, 8'h00, 8'hFF); step();
    setin(0,0,0,0,0, 8'h00, 8'hFF); step();
    chk("down.out1", out1, 8'hFF);
    chk("down.done1", done1, 1'b1);
    step();
    dir = 1'b0;
`endif

    // Randomized phase against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 3) == 0);
      pause = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      load  = ($urandom_range(0, 9) == 0);
      load_val = ($urandom_range(0, 7) == 0) ? 8'($urandom) : enc($urandom_range(0, 99));
      case ($urandom_range(0, 3))
        0: limit = 8'($urandom);
        1: limit = enc((m1.cnt + $urandom_range(0, 3)) % 100);
        2: limit = enc((m3.cnt + $urandom_range(0, 2)) % 100);
        default: limit = enc($urandom_range(0, 99));
      endcase
`ifdef CODE2421_DOWN_EN
      dir = $urandom_range(0, 1) == 1;
      if (dir && $urandom_range(0, 1) == 1)
        limit = enc((m1.cnt + 99) % 100);
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/code2421_seq_ctrl.md
CODE2421_SEQ_CTRL -- requirements
Module: code2421_seq_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning clock cycles in RUN per count advance (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, a request to begin counting, sampled only in IDLE.
REQ-005 SHALL have port pause, input, 1, a level that holds counting while high.
REQ-006 SHALL have port stop, input, 1, an abort to IDLE from any state.
REQ-007 SHALL have port load, input, 1, a request to load load_val, sampled only in IDLE.
REQ-008 SHALL have port load_val, input, 8, two 2421 digits {tens,units}.
REQ-009 SHALL have port limit, input, 8, the terminal value as two 2421 digits.
REQ-010 SHALL have port out, output, 8, the current count as two 2421 digits.
REQ-011 SHALL have port busy, output, 1, high in RUN or HOLD.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse on reaching limit.
REQ-013 SHALL have port err, output, 1, a sticky illegal-code flag.

Function
REQ-014 SHALL use 2421 digit codes 0..9 = 0000,0001,0010,0011,0100,1011,1100,1101,1110,1111; all other nibbles are illegal.
REQ-015 SHALL implement FSM states IDLE, RUN, HOLD and DONE.
REQ-016 SHALL move IDLE->RUN on start when limit is legal and err is 0; otherwise start is ignored and err is set if limit is illegal.
REQ-017 SHALL move RUN->HOLD when pause=1, HOLD->RUN when pause=0, and RUN->DONE on the advance whose new out equals limit.
REQ-018 SHALL move DONE->IDLE unconditionally; done=1 only during DONE.
REQ-019 SHALL send stop=1 from RUN, HOLD or DONE to IDLE next cycle with out retained; stop has priority over pause, start and advance.
REQ-020 SHALL clear the prescale counter on IDLE->RUN and hold it in HOLD; the first advance lands PRESCALE cycles after RUN is entered.
REQ-021 SHALL advance the count by +1 decimal per step: units 9->0 with a carry into tens, and 99->00 wrap without asserting done unless limit = 00.
REQ-022 SHALL, on load in IDLE with a legal load_val, set out <= load_val and clear err next cycle; an illegal load_val leaves out unchanged and sets err.
REQ-023 SHALL give load priority over start when both are asserted in the same IDLE cycle; start is then ignored.
REQ-024 SHALL compare against limit only on an advance, so a start at out==limit counts 100 steps before done.
REQ-025 SHALL have no outputs depending combinationally on any input.

Reset
REQ-026 SHALL on rst put state in IDLE and set out=8'h00, busy=0, done=0, err=0, prescale=0.
REQ-027 SHALL let rst asserted mid-RUN override every other input in that cycle.

Configuration
REQ-028 SHALL, with CODE2421_DOWN_EN defined, add an input dir (1 bit, 0=up, 1=down) sampled at each advance; down counting runs units 0->9 with a borrow from tens, 00->99 wraps, and the limit rule is unchanged.
REQ-029 SHALL, without CODE2421_DOWN_EN, have no dir port and count up only.

Structure
REQ-030 SHALL place the state enum, the ten 2421 digit constants and the legal-code check function in the shared package code2421_pkg.
REQ-031 SHALL instantiate sub-module code2421_digit twice: one 4-bit 2421 digit with load, inc (and dec under the macro), carry/borrow out and a legal flag.

Verification
REQ-032 SHALL cover: rst, then load=1 with load_val=8'h0B (05) -> out=8'h0B and err=0 in the next cycle.
REQ-033 SHALL cover: PRESCALE=1, out=8'h0F (09), limit=8'h12 (12), start -> out steps 10, 11, 12; done pulses one cycle; then IDLE with busy=0.
REQ-034 SHALL cover: out=8'hFF (99), limit=8'h01, start -> out 00 then 01, with done on 01 only.
REQ-035 SHALL cover: PRESCALE=3 with pause high for 5 cycles mid-RUN -> out frozen; the remaining prescale cycles resume after pause drops.
REQ-036 SHALL cover: load_val=8'h05 (illegal nibble 0101) -> err=1 and out unchanged; a subsequent start is ignored; a legal load clears err.
REQ-037 SHALL cover: stop and pause asserted together in RUN -> IDLE next cycle with out retained; under CODE2421_DOWN_EN, dir=1 from 00 -> 99.
